// File: rtl/traffic_pkg.sv
// Shared traffic-controller types: lane count width, lane ordering and count type.
// Used by the occupancy counter and by the arbitration and night-time stages.
package traffic_pkg;

    localparam int unsigned LANES   = 8;
    localparam int unsigned COUNT_W = 8;

    typedef logic [COUNT_W-1:0] lane_count_t;

    typedef enum logic [2:0] {
        LANE_N1,
        LANE_N2,
        LANE_E1,
        LANE_E2,
        LANE_S1,
        LANE_S2,
        LANE_W1,
        LANE_W2
    } lane_idx_t;

endpackage

// File: rtl/lane_counter_cell.sv
// One lane: optional arrival synchronizer (ARRIVAL_SYNC_EN), rising-edge detect,
// green departure timer and saturating up/down car count with sat flag.
module lane_counter_cell
    import traffic_pkg::*;
#(
    parameter int unsigned DEPART_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        arrive,
    input  logic        green,
    output lane_count_t count,
    output logic        sat
);

    localparam logic [7:0] TIMER_LAST = 8'(DEPART_DIV - 1);

    logic        sampled;
    logic        prev_q;
    logic [1:0]  arm_q;
    logic        armed;
    logic        inc;
    logic        dec;
    logic [7:0]  timer_q;
    lane_count_t count_d;

`ifdef ARRIVAL_SYNC_EN
    // Edge detection stays disarmed until the synchronizer output reflects the pin.
    localparam logic [1:0] ARM_EDGES = 2'd3;
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], arrive};
    end

    assign sampled = sync_q[1];
`else
    localparam logic [1:0] ARM_EDGES = 2'd1;
    assign sampled = arrive;
`endif

    // A level already high when reset releases must not look like a new car.
    assign armed = (arm_q == ARM_EDGES);
    assign inc   = armed & sampled & ~prev_q;
    assign dec   = green & (timer_q == TIMER_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            prev_q <= sampled;
            if (!armed) arm_q <= arm_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               timer_q <= '0;
        else if (clr || !green)   timer_q <= '0;
        else if (dec)             timer_q <= '0;
        else                      timer_q <= timer_q + 8'd1;
    end

    always_comb begin
        count_d = count;
        if (inc && !dec && count != '1)      count_d = count + 1'b1;
        else if (dec && !inc && count != '0) count_d = count - 1'b1;
        if (clr)                             count_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else begin
            count <= count_d;
            sat   <= (count_d == '1);
        end
    end

endmodule

// File: rtl/lane_car_counter.sv
// Per-lane vehicle occupancy counter feeding day-time arbitration.
// Build option: define ARRIVAL_SYNC_EN to synchronize the arrive sensors.
module lane_car_counter
    import traffic_pkg::*;
#(
    parameter int unsigned DEPART_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [LANES-1:0]         arrive,
    input  logic [LANES-1:0]         green,
    output logic [LANES*COUNT_W-1:0] lane,
    output logic [LANES-1:0]         sat
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_counter_cell #(
            .DEPART_DIV(DEPART_DIV)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .arrive(arrive[i]),
            .green (green[i]),
            .count (lane[i*COUNT_W +: COUNT_W]),
            .sat   (sat[i])
        );
    end

endmodule

// File: tb/tb_lane_car_counter.sv
// Directed self-checking bench for lane_car_counter at DEPART_DIV=4.
// Arrival latency follows ARRIVAL_SYNC_EN (1 or 3 edges).
module tb_lane_car_counter;
    import traffic_pkg::*;

`ifdef ARRIVAL_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic                     clk;
    logic                     rst_n;
    logic                     clr;
    logic [LANES-1:0]         arrive;
    logic [LANES-1:0]         green;
    logic [LANES*COUNT_W-1:0] lane;
    logic [LANES-1:0]         sat;

    int checks = 0;
    int errors = 0;

    lane_car_counter #(
        .DEPART_DIV(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .arrive(arrive),
        .green (green),
        .lane  (lane),
        .sat   (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        repeat (3) tick();
    endtask

    task automatic pulse(input int idx, input int n);
        for (int k = 0; k < n; k++) begin
            arrive[idx] = 1'b1;
            tick();
            arrive[idx] = 1'b0;
            tick();
        end
    endtask

    function automatic logic [7:0] lv(input int idx);
        return lane[idx*COUNT_W +: COUNT_W];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int model;
        bit m_inc, m_dec;

        rst_n  = 1'b0;
        clr    = 1'b0;
        arrive = '0;
        green  = '0;
        arrive[LANE_E2] = 1'b1;
        #12;
        chk("reset_lane", lane, 64'd0);
        chk("reset_sat", 64'(sat), 64'd0);

        // Arrive already high at release is not a car
        #20 rst_n = 1'b1;
        repeat (5) tick();
        chk("prehigh_not_counted", lv(3), 64'd0);
        arrive[LANE_E2] = 1'b0;
        flush();

        // Single arrival on lane 2
        arrive[LANE_E1] = 1'b1;
        chk("arr_before_edge", lv(2), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) arrive[LANE_E1] = 1'b0;
            if (k == LAT - 1) chk("arr_not_yet", lv(2), 64'd0);
            if (k == LAT) chk("arr_latency", lv(2), 64'd1);
        end
        chk("arr_single_count", lv(2), 64'd1);
        chk("arr_other_lanes", lane & ~(64'hFF << 16), 64'd0);
        flush();

        // Departures on lane 0 at every 4th green edge
        pulse(0, 3);
        flush();
        chk("dep_preload", lv(0), 64'd3);
        green[LANE_N1] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk($sformatf("dep_edge%0d", e), lv(0), 64'(3 - e / 4));
        end
        repeat (5) tick();
        chk("dep_no_underflow", lv(0), 64'd0);
        green[LANE_N1] = 1'b0;

        // Green interruption discards the partial interval
        pulse(1, 2);
        flush();
        green[LANE_N2] = 1'b1;
        repeat (3) tick();
        green[LANE_N2] = 1'b0;
        tick();
        chk("gint_held", lv(1), 64'd2);
        green[LANE_N2] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("gint_edge%0d", e), lv(1), (e < 4) ? 64'd2 : 64'd1);
        end
        green[LANE_N2] = 1'b0;

        // Arrival coinciding with a decrement, at 5 and at 0
        pulse(4, 5);
        flush();
        chk("sim_preload", lv(4), 64'd5);
        green[LANE_S1] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            if (e == 5 - LAT) arrive[LANE_S1] = 1'b1;
            tick();
        end
        chk("sim_hold5", lv(4), 64'd5);
        arrive[LANE_S1] = 1'b0;
        green[LANE_S1]  = 1'b0;
        flush();
        green[LANE_S2] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            if (e == 5 - LAT) arrive[LANE_S2] = 1'b1;
            tick();
        end
        chk("sim_hold0", lv(5), 64'd0);
        arrive[LANE_S2] = 1'b0;
        green[LANE_S2]  = 1'b0;
        flush();

        // Saturation on lane 7
        pulse(7, 254);
        flush();
        chk("sat_254_count", lv(7), 64'd254);
        chk("sat_254_flag", 64'(sat[7]), 64'd0);
        pulse(7, 1);
        flush();
        chk("sat_255_count", lv(7), 64'd255);
        chk("sat_255_flag", 64'(sat[7]), 64'd1);
        pulse(7, 5);
        flush();
        chk("sat_260_count", lv(7), 64'd255);
        chk("sat_260_flags", 64'(sat), 64'h80);
        green[LANE_W2] = 1'b1;
        repeat (4) tick();
        green[LANE_W2] = 1'b0;
        chk("sat_dep_count", lv(7), 64'd254);
        chk("sat_dep_flag", 64'(sat[7]), 64'd0);

        // Asynchronous reset mid-cycle with green active
        green = '1;
        repeat (2) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("areset_lane", lane, 64'd0);
        chk("areset_sat", 64'(sat), 64'd0);
        #2 rst_n = 1'b1;
        model = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 2) arrive[LANE_W1] = 1'b1;
            if (e == 5) arrive[LANE_W1] = 1'b0;
            m_inc = (e == 2 + LAT);
            m_dec = (e % 4 == 0);
            if (m_inc && !m_dec) model++;
            else if (m_dec && !m_inc && model > 0) model--;
            chk($sformatf("post_reset_edge%0d", e), lv(6), 64'(model));
        end
        green = '0;
        flush();

        // Synchronous clear overrides a coincident arrival
        pulse(3, 2);
        flush();
        chk("clr_preload", lv(3), 64'd2);
        arrive[LANE_N1] = 1'b1;
        repeat (LAT - 1) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_lane", lane, 64'd0);
        chk("clr_sat", 64'(sat), 64'd0);
        repeat (4) tick();
        chk("clr_history", lv(0), 64'd0);
        arrive[LANE_N1] = 1'b0;
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lane_car_counter.md
# lane_car_counter

Per-lane vehicle occupancy counter that feeds the day-time arbitration stage. It counts car arrivals from eight lane sensors and retires cars while the lane's light is green, one car per DEPART_DIV cycles. It presents an 8×8-bit count array in the same N1,N2,E1,E2,S1,S2,W1,W2 order that day-time arbitration consumes. The lane light outputs of that stage are fed back here as `green`.

## Interface
- LANES, 8, number of lanes; index order N1,N2,E1,E2,S1,S2,W1,W2
- COUNT_W, 8, width of each lane count
- DEPART_DIV, 4, clock cycles of green per departing car; legal range 1 to 255

- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  reset, asynchronous assert, active-low
- clr  input  1  synchronous clear of all counts and timers
- arrive  input  LANES  level sensor per lane; each 0→1 transition is one car
- green  input  LANES  per-lane light state from arbitration; 1 = cars may depart
- lane  output  LANES×COUNT_W  registered car count per lane
- sat  output  LANES  registered; 1 when that lane's count equals 2^COUNT_W−1

## Operation
- **Reset.** rst_n low clears the following, independent of clk:
  - lane to 0
  - sat to 0
  - all departure timers to 0
  - all edge and synchronizer flops to 0
- **Reset release.** An arrive input already high at rst_n release is not counted; the edge detector sees 0 as the previous value only after one sampled cycle.
- **Arrival.** `inc[i]` = arrive sampled high this edge AND sampled low the previous edge.
- **Departure timer.**
  - While green[i]=1, the per-lane timer increments each cycle.
  - When the timer equals DEPART_DIV−1, it wraps to 0 and asserts `dec[i]` for that cycle.
  - While green[i]=0, the timer is held at 0.
  - A partially elapsed interval is discarded when green drops.
- **Count update, per lane per edge:**
  - inc and not dec: count+1, except hold when saturated.
  - dec and not inc: count−1, except hold when count is 0.
  - inc and dec together: count unchanged, including at 0 and at saturation.
  - neither: hold.
- **No wrap-around.** Counts never wrap in either direction.
- **sat.** sat[i] is registered alongside lane[i] and reflects the updated value.
- **clr.** Zeroes counts, sat and timers on the next edge. It takes priority over inc and dec. Edge-detect history is still updated that cycle.
- **Lane independence.** Lanes are fully independent; no cross-lane arithmetic.

## Timing
- Arrival latency without the macro: count changes on the first edge that samples arrive high; lane is visible 1 cycle after arrive rises.
- Departure latency: the first decrement lands on the DEPART_DIV-th consecutive edge with green high. Subsequent decrements follow every DEPART_DIV edges.
- DEPART_DIV=1: one decrement per cycle while green.
- Pulse width: an arrive pulse must be high for at least 1 sampled cycle and low for at least 1 sampled cycle between cars. A pulse shorter than one clock may be missed.
- Outputs are fully registered; there is no combinational path from any input to lane or sat.
- green is expected to be glitch-free and registered upstream. A 1-cycle green pulse with DEPART_DIV>1 causes no departure.

## Configuration
- Macro: ARRIVAL_SYNC_EN.
- **Defined:** each arrive bit passes through a two-flop synchronizer before edge detection. Arrival latency becomes 3 cycles (count visible on the 3rd edge after arrive rises). Synchronizer flops reset to 0.
- **Undefined:** arrive feeds edge detection directly, with 1-cycle latency. Sensors must then be synchronous to clk.
- Departure behaviour is identical in both builds.

## Structure
- **Shared package `traffic_pkg`:**
  - LANES and COUNT_W constants
  - `lane_count_t` (logic [COUNT_W-1:0])
  - lane index constants LANE_N1…LANE_W2
  - These are shared with the arbitration and night-time stages.
- **Sub-module `lane_counter_cell`:** one lane's edge detector, optional synchronizer, departure timer, saturating up/down counter and sat flag. The top instantiates LANES copies and packs the outputs.

## Test plan
- **Single arrival.** Reset, then arrive[2] pulses high for 2 cycles, green=0 → lane[2]=1 one cycle after the rise (3 with ARRIVAL_SYNC_EN); other lanes stay 0.
- **Departure at DEPART_DIV=4.** Preload lane[0]=3 via 3 pulses, then green[0]=1 for 12 cycles → lane[0] goes 2, 1, 0 at green edges 4, 8 and 12; it stays 0 with green held and never underflows.
- **Saturation.** 260 arrival pulses on lane 7 → lane[7]=255 and sat[7]=1 from the 255th car. A departure then gives 254 with sat[7]=0.
- **Simultaneous events.** An arrival coincides with a decrement edge on lane 4 holding 5 → lane[4] stays 5. The same coincidence at count 0 → stays 0.
- **Reset and clr mid-operation.**
  - rst_n dropped asynchronously mid-cycle while counts are nonzero and green is active → all outputs are 0 immediately.
  - After release with green still high, the first decrement arrives only after a full DEPART_DIV cycles.
  - clr pulse → all counts 0 on the next edge.
- **Green interruption.** green[1]=1 for 3 cycles, 0 for 1 cycle, 1 again with DEPART_DIV=4 → no decrement until 4 cycles after the re-assert.
